// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - ALU result capture: overflow, condition code, trap hold, 2-entry skid buffer
module alu_result_stage #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [0:WIDTH-1] in_r,
  input  logic             in_c,
  input  logic             in_n,
  input  logic             in_z,
  input  logic             in_a_sign,
  input  logic             in_b_sign,
  input  logic             in_add,
  input  logic             in_sub,
  input  logic             in_unsigned,
  input  logic             in_trap_en,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [0:WIDTH-1] out_r,
  output logic [3:0]       out_cc,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_trap,
  output logic             trap_pend
);
  typedef enum logic {RUN, TRAP_HOLD} state_t;

  state_t           state, state_n;
  logic             m_valid, s_valid, m_valid_n, s_valid_n;
  logic [0:WIDTH-1] m_r, s_r;
  logic [3:0]       m_cc, s_cc;
  logic [TAG_W-1:0] m_tag, s_tag;
  logic             m_trap, s_trap;

  logic             v_signed, v_unsigned, v, new_trap;
  logic [3:0]       new_cc;
  logic             accept, emit;
  logic             m_load_new, m_load_s, s_load_new;

  // bit 0 is the sign bit of the result
  assign v_signed   = (in_a_sign == in_b_sign) & (in_r[0] != in_a_sign);
  assign v_unsigned = in_sub ? ~in_c : in_c;
  assign v          = in_add & (in_unsigned ? v_unsigned : v_signed);
  assign new_cc     = {in_n, in_z, in_add & in_c, v};
  assign new_trap   = in_trap_en & v;

  assign accept = in_valid & in_ready;
  assign emit   = m_valid & out_ready;

  always_comb begin
    m_valid_n  = m_valid;
    s_valid_n  = s_valid;
    m_load_new = 1'b0;
    m_load_s   = 1'b0;
    s_load_new = 1'b0;
    state_n    = state;
    if (accept && emit) begin
      if (s_valid) begin
        m_load_s   = 1'b1;
        s_load_new = 1'b1;
      end else begin
        m_load_new = 1'b1;
      end
    end else if (emit) begin
      if (s_valid) begin
        m_load_s  = 1'b1;
        s_valid_n = 1'b0;
      end else begin
        m_valid_n = 1'b0;
      end
    end else if (accept) begin
      if (!m_valid) begin
        m_load_new = 1'b1;
        m_valid_n  = 1'b1;
      end else begin
        s_load_new = 1'b1;
        s_valid_n  = 1'b1;
      end
    end
    if (accept && new_trap) state_n = TRAP_HOLD;
  end

  // flush only clears valids and state; data registers keep their contents
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      m_valid   <= 1'b0;
      s_valid   <= 1'b0;
      in_ready  <= 1'b0;
      trap_pend <= 1'b0;
      m_r       <= '0;
      m_cc      <= '0;
      m_tag     <= '0;
      m_trap    <= 1'b0;
      s_r       <= '0;
      s_cc      <= '0;
      s_tag     <= '0;
      s_trap    <= 1'b0;
    end else if (flush) begin
      state     <= RUN;
      m_valid   <= 1'b0;
      s_valid   <= 1'b0;
      in_ready  <= 1'b1;
      trap_pend <= 1'b0;
    end else begin
      state     <= state_n;
      m_valid   <= m_valid_n;
      s_valid   <= s_valid_n;
      in_ready  <= ~s_valid_n & (state_n == RUN);
      trap_pend <= (state_n == TRAP_HOLD);
      if (m_load_s) begin
        m_r    <= s_r;
        m_cc   <= s_cc;
        m_tag  <= s_tag;
        m_trap <= s_trap;
      end else if (m_load_new) begin
        m_r    <= in_r;
        m_cc   <= new_cc;
        m_tag  <= in_tag;
        m_trap <= new_trap;
      end
      if (s_load_new) begin
        s_r    <= in_r;
        s_cc   <= new_cc;
        s_tag  <= in_tag;
        s_trap <= new_trap;
      end
    end
  end

  assign out_valid = m_valid;
  assign out_r     = m_r;
  assign out_cc    = m_cc;
  assign out_tag   = m_tag;
  assign out_trap  = m_trap;
endmodule

// File: tb/tb_alu_result_stage.sv
// tb/tb_alu_result_stage.sv - directed and random bench for alu_result_stage against a queue model
module tb_alu_result_stage;
  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic        in_ready, out_valid, out_trap, trap_pend;
  logic [31:0] in_r, out_r;
  logic        in_c, in_n, in_z, in_a_sign, in_b_sign;
  logic        in_add, in_sub, in_unsigned, in_trap_en;
  logic [4:0]  in_tag, out_tag;
  logic [3:0]  out_cc;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] r;
    logic [3:0]  cc;
    logic [4:0]  tag;
    logic        trap;
  } ent_t;

  ent_t q[$];
  ent_t cur;
  logic m_ready = 1'b0;
  logic trapped = 1'b0;

  alu_result_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_r(in_r), .in_c(in_c), .in_n(in_n), .in_z(in_z),
    .in_a_sign(in_a_sign), .in_b_sign(in_b_sign),
    .in_add(in_add), .in_sub(in_sub), .in_unsigned(in_unsigned),
    .in_trap_en(in_trap_en), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_r(out_r), .out_cc(out_cc), .out_tag(out_tag),
    .out_trap(out_trap), .trap_pend(trap_pend)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive an ALU op from its operands; expected flags come from plain integer arithmetic.
  task automatic set_op(input logic [31:0] aa, input logic [31:0] bb, input logic add,
                        input logic sub, input logic uns, input logic ten);
    logic [31:0] bi;
    logic [32:0] s;
    longint      sa;
    logic        v;
    bi = sub ? ~bb : bb;
    s  = {1'b0, aa} + {1'b0, bi} + {32'd0, sub};
    if (add) begin
      in_r = s[31:0];
      in_c = s[32];
    end else begin
      in_r = aa ^ bb;
      in_c = bb[0];
    end
    in_n        = in_r[31];
    in_z        = (in_r == 32'd0);
    in_a_sign   = aa[31];
    in_b_sign   = bi[31];
    in_add      = add;
    in_sub      = sub;
    in_unsigned = uns;
    in_trap_en  = ten;
    in_tag      = 5'($urandom);
    sa = sub ? (longint'($signed(aa)) - longint'($signed(bb)))
             : (longint'($signed(aa)) + longint'($signed(bb)));
    if (!add)     v = 1'b0;
    else if (uns) v = sub ? (aa < bb) : ((longint'(aa) + longint'(bb)) > 64'sd4294967295);
    else          v = (sa > 64'sd2147483647) || (sa < -64'sd2147483648);
    cur.r    = in_r;
    cur.cc   = {in_n, in_z, add & in_c, v};
    cur.tag  = in_tag;
    cur.trap = ten & v;
  endtask

  task automatic check_outputs();
    chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
    chk("in_ready", {63'd0, in_ready}, {63'd0, m_ready});
    chk("trap_pend", {63'd0, trap_pend}, {63'd0, trapped});
    if (q.size() > 0) begin
      chk("out_r", {32'd0, out_r}, {32'd0, q[0].r});
      chk("out_cc", {60'd0, out_cc}, {60'd0, q[0].cc});
      chk("out_tag", {59'd0, out_tag}, {59'd0, q[0].tag});
      chk("out_trap", {63'd0, out_trap}, {63'd0, q[0].trap});
    end
  endtask

  // Called at a falling edge: check, drive, clock, update the model.
  task automatic step(input logic iv, input logic ordy, input logic fl);
    logic acc, em;
    check_outputs();
    in_valid  = iv;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    acc = iv & m_ready;
    em  = ordy & (q.size() > 0);
    if (fl) begin
      q.delete();
      trapped = 1'b0;
      m_ready = 1'b1;
    end else begin
      if (em) void'(q.pop_front());
      if (acc) begin
        q.push_back(cur);
        if (cur.trap) trapped = 1'b1;
      end
      m_ready = !trapped && (q.size() < 2);
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_op(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_r", {32'd0, out_r}, 64'd0);
    chk("rst_out_cc", {60'd0, out_cc}, 64'd0);
    chk("rst_out_tag", {59'd0, out_tag}, 64'd0);
    chk("rst_out_trap", {63'd0, out_trap}, 64'd0);
    chk("rst_trap_pend", {63'd0, trap_pend}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    rst_n = 1'b1;
    step(1'b0, 1'b1, 1'b0);
    chk("rel_in_ready", {63'd0, in_ready}, 64'd1);

    // back-to-back flow 1..4
    for (int k = 1; k <= 4; k++) begin
      set_op(32'(k), 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      chk("flow_r", {32'd0, out_r}, 64'(k));
      chk("flow_ready", {63'd0, in_ready}, 64'd1);
    end
    step(1'b0, 1'b1, 1'b0);

    // signed overflow
    set_op(32'h7FFF_FFFF, 32'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("sovf_r", {32'd0, out_r}, 64'h8000_0000);
    chk("sovf_cc", {60'd0, out_cc}, 64'b1001);

    // unsigned subtract with and without borrow
    set_op(32'd0, 32'd1, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("ubor_r", {32'd0, out_r}, 64'hFFFF_FFFF);
    chk("ubor_v", {63'd0, out_cc[0]}, 64'd1);
    set_op(32'd5, 32'd5, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("unob_cc", {60'd0, out_cc}, 64'b0110);
    step(1'b0, 1'b1, 1'b0);

    // backpressure: A, B stored, C held by the source
    set_op(32'hA, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    set_op(32'hB, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("bp_ready_low", {63'd0, in_ready}, 64'd0);
    set_op(32'hC, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("bp_head_a", {32'd0, out_r}, 64'hA);
    step(1'b1, 1'b1, 1'b0);
    chk("bp_head_b", {32'd0, out_r}, 64'hB);
    step(1'b1, 1'b1, 1'b0);
    chk("bp_head_c", {32'd0, out_r}, 64'hC);
    step(1'b0, 1'b1, 1'b0);
    chk("bp_empty", {63'd0, out_valid}, 64'd0);

    // trap freezes the input until flush
    set_op(32'h7FFF_FFFF, 32'd1, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    chk("trap_out", {63'd0, out_trap}, 64'd1);
    chk("trap_pend_hi", {63'd0, trap_pend}, 64'd1);
    chk("trap_ready_lo", {63'd0, in_ready}, 64'd0);
    set_op(32'd1, 32'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) step(1'b1, 1'b1, 1'b0);
    chk("trap_blocked", {63'd0, out_valid}, 64'd0);
    step(1'b0, 1'b0, 1'b1);
    chk("flush_pend_lo", {63'd0, trap_pend}, 64'd0);
    chk("flush_ready_hi", {63'd0, in_ready}, 64'd1);

    // flush with both entries full and a simultaneous offer
    set_op(32'h11, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    set_op(32'h22, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    set_op(32'h33, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    chk("flush_empty", {63'd0, out_valid}, 64'd0);
    repeat (3) step(1'b0, 1'b1, 1'b0);

    // asynchronous reset mid-cycle with both entries full
    set_op(32'h44, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_r", {32'd0, out_r}, 64'd0);
    chk("arst_cc", {60'd0, out_cc}, 64'd0);
    chk("arst_ready", {63'd0, in_ready}, 64'd0);
    q.delete();
    trapped = 1'b0;
    m_ready = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b1, 1'b0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic iv, ordy, fl;
      set_op($urandom, $urandom, ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
             $urandom_range(0, 1), ($urandom_range(0, 15) == 0));
      if ($urandom_range(0, 7) == 0) begin
        in_r[31] = ~in_r[31];
        set_op({1'b0, 31'($urandom)}, {1'b0, 31'($urandom)}, 1'b1, 1'b0, 1'b0,
               $urandom_range(0, 1));
      end
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      fl   = trapped ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 63) == 0);
      step(iv, ordy, fl);
    end
    step(1'b0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Execute-to-memory pipeline stage directly downstream of the ALU.
- Captures the ALU result and flags, derives signed/unsigned overflow and a 4-bit condition code, and optionally raises an overflow trap.
- Uses a 2-entry skid buffer with valid/ready on both sides, so a registered ready never drops a word.
- Freezes after a trap until the pipeline is flushed.

Parameters:
- WIDTH, 32, data word width; bit 0 is the MSB (big-endian numbering, as elsewhere in the core).
- TAG_W, 5, destination-register tag width.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  stage can accept; a registered signal.
- in_r  in  WIDTH  ALU result.
- in_c  in  1  ALU carry out.
- in_n  in  1  ALU negative flag.
- in_z  in  1  ALU zero flag.
- in_a_sign  in  1  sign (bit 0) of the adder A operand after shift.
- in_b_sign  in  1  sign of the adder B operand after optional inversion.
- in_add  in  1  the op is an adder op; overflow is evaluated only when set.
- in_sub  in  1  the adder op is a subtraction (B inverted, carry in 1).
- in_unsigned  in  1  select unsigned overflow semantics.
- in_trap_en  in  1  overflow must trap.
- in_tag  in  TAG_W  destination tag.
- out_valid  out  1  downstream word valid.
- out_ready  in  1  downstream accepts.
- out_r  out  WIDTH  registered result.
- out_cc  out  4  condition code {N,Z,C,V}.
- out_tag  out  TAG_W  registered tag.
- out_trap  out  1  this word carries an overflow trap.
- trap_pend  out  1  stage is frozen in TRAP_HOLD.

Behaviour:
- Overflow V, computed at capture:
  - When in_add=0, V=0.
  - Signed: V = (in_a_sign==in_b_sign) & (in_r[0]!=in_a_sign).
  - Unsigned: V = in_sub ? ~in_c : in_c.
- C field: in_c is passed through only when in_add=1, else 0.
- Trap bit stored with the entry: in_trap_en & V.
- Storage: main entry M drives the out_* ports; skid entry S. Each entry holds r, cc, tag, trap and a valid bit.
- Accept occurs on in_valid & in_ready.
- Emit occurs on out_valid & out_ready; out_valid = M.valid.
- Emit without accept: M takes S if S.valid, else M.valid is cleared.
- Accept without emit: the word goes to M if M is empty, else to S.
- Accept and emit in the same cycle: if S.valid, S→M and the new word→S; otherwise the new word→M.
- in_ready (registered) = ~S.valid_next & (state_next==RUN).
  - Zero bubbles in steady flow.
  - in_valid while in_ready=0 is ignored; upstream holds it.
- State machine:
  - RUN→TRAP_HOLD when a word with trap=1 is accepted.
  - In TRAP_HOLD, in_ready=0 and trap_pend=1. Entries already stored drain normally.
  - The trap word is still presented with out_trap=1.
  - TRAP_HOLD→RUN only on flush.
- Flush:
  - Next edge: M.valid=S.valid=0, state=RUN, in_ready=1.
  - Flush wins over a simultaneous accept or emit; the accepted word is discarded.
- Latency: one cycle from accept to out_valid when the stage is empty.
- Ordering: strict FIFO, never reordered.
- Asynchronous reset (rst_n=0): out_valid=0, out_r=0, out_cc=0, out_tag=0, out_trap=0, trap_pend=0, state=RUN, both valids cleared.
  - in_ready is 0 during reset and 1 at the first edge after release.
  - Reset mid-transfer drops all stored words.
- Data registers load only on capture or shift; there is no toggling when idle.
- No combinational path from in_valid to in_ready, or from out_ready to in_ready.

Test Plan:
1. Reset then flow: 4 words back-to-back with out_ready=1, in_r=1,2,3,4 → out_r=1,2,3,4 on consecutive cycles, each 1 cycle after accept; in_ready stays 1.
2. Signed overflow: in_add=1, in_unsigned=0, in_a_sign=0, in_b_sign=0, in_r=32'h8000_0000, in_c=0 → out_cc=4'b1001 (N=1, V=1).
3. Unsigned subtract borrow: in_add=1, in_sub=1, in_unsigned=1, in_c=0, in_r=32'hFFFF_FFFF → V=1. Repeat with in_c=1, in_r=0 → out_cc=4'b0110.
4. Backpressure: out_ready=0, offer 3 words (A, B, C) → A in M, B in S, in_ready=0 the cycle after B; C held by the source. Release out_ready → A, B, C delivered in order with no loss or duplication.
5. Trap: in_trap_en=1 with a word that overflows, followed by a normal word → out_trap=1 on the trap word, trap_pend=1, in_ready=0. The next word is not accepted until flush. After flush, trap_pend=0 and in_ready=1 on the next cycle.
6. Flush/reset mid-operation: both entries full, assert flush together with in_valid → out_valid=0 next cycle and nothing later emerges. Repeat with rst_n pulsed low asynchronously mid-cycle → outputs zero immediately.
